// File: rtl/regfile_dump_ctrl.sv
// Debug read-out engine: walks a register-address range through a spare
// combinational read port and streams {address, data, last} over valid/ready.
module regfile_dump_ctrl #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_reg,
  input  logic [AW-1:0] last_reg,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_addr,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] lst, lst_nxt;
  logic [DW-1:0] m_data_nxt;
  logic [AW-1:0] m_addr_nxt;
  logic          m_last_nxt;
  logic          m_valid_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  // The read port address is always the registered pointer.
  assign rf_ra = ptr;

  // Next-state and registered-output logic; abort has priority everywhere.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    lst_nxt     = lst;
    m_data_nxt  = m_data;
    m_addr_nxt  = m_addr;
    m_last_nxt  = m_last;
    m_valid_nxt = m_valid;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          ptr_nxt   = first_reg;
          lst_nxt   = last_reg;
          busy_nxt  = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (abort) begin
          busy_nxt    = 1'b0;
          m_valid_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          m_data_nxt  = rf_rd;
          m_addr_nxt  = ptr;
          m_last_nxt  = (ptr == lst);
          m_valid_nxt = 1'b1;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          busy_nxt    = 1'b0;
          m_valid_nxt = 1'b0;
          state_nxt   = IDLE;
        end else if (m_ready) begin
          m_valid_nxt = 1'b0;
          if (m_last) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ptr_nxt   = ptr + AW'(1);
            state_nxt = READ;
          end
        end
      end
      default: begin
        busy_nxt    = 1'b0;
        m_valid_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      lst     <= '0;
      m_data  <= '0;
      m_addr  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      lst     <= lst_nxt;
      m_data  <= m_data_nxt;
      m_addr  <= m_addr_nxt;
      m_last  <= m_last_nxt;
      m_valid <= m_valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: expected words are queued when a dump
// starts and compared against every valid cycle of the output stream.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [4:0]  m_addr;
  logic        m_last;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          edges;
  int          base;

  regfile_dump_ctrl #(.AW(5), .DW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rf_ra     (rf_ra),
    .rf_rd     (rf_rd),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_addr    (m_addr),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  assign rf_rd = rf[rf_ra];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare any presented word against the scoreboard head, then advance one edge.
  task automatic tick();
    exp_t e;
    if (m_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("stray_word", 32'(m_valid), 32'd0);
      end else begin
        e = q[0];
        chk("data", m_data, e.data);
        chk("addr", 32'(m_addr), 32'(e.addr));
        chk("last", 32'(m_last), 32'(e.last));
        if (m_ready) void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic push_range(input logic [4:0] f, input logic [4:0] l);
    int   n;
    logic [4:0] a;
    n = int'(5'(l - f)) + 1;
    for (int k = 0; k < n; k++) begin
      a = f + 5'(k);
      q.push_back('{data: rf[a], addr: a, last: (k == n - 1)});
    end
  endtask

  // Full dump with optional per-word stall and an ignored start pulse while busy.
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int stall,
                         input bit poke, output int edges_out);
    int n, sc, got, e;
    bit hs;
    n = int'(5'(l - f)) + 1;
    push_range(f, l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("read_no_valid", 32'(m_valid), 32'd0);
    got = done_cnt;
    e = 0;
    sc = 0;
    while (done_cnt == got && e < 2000) begin
      if (m_valid && sc < stall) begin
        m_ready = 1'b0;
        sc++;
      end else begin
        m_ready = 1'b1;
      end
      if (poke && e == 4) begin
        start     = 1'b1;
        first_reg = 5'd20;
        last_reg  = 5'd20;
      end else begin
        start = 1'b0;
      end
      hs = m_valid && m_ready;
      tick();
      if (hs) sc = 0;
      e++;
    end
    start = 1'b0;
    edges_out = e;
    chk("done_seen", 32'(done_cnt - got), 32'd1);
    chk("edges_to_done", 32'(e), 32'(n * (2 + stall)));
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("valid_after_done", 32'(m_valid), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(1000 + i);
    rf[0] = 32'd0;

    // Reset values
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_rf_ra", 32'(rf_ra), 32'd0);

    // Full dump 0..31; done lands 64 edges after the start edge (65 counting it)
    do_dump(5'd0, 5'd31, 0, 1'b0, edges);
    chk("full_edges", 32'(edges), 32'd64);
    chk("rf_ra_idle", 32'(rf_ra), 32'd31);

    // Wrap through 31 -> 0
    do_dump(5'd30, 5'd1, 0, 1'b0, edges);
    chk("wrap_edges", 32'(edges), 32'd8);

    // Single word
    rf[5] = 32'd54321;
    do_dump(5'd5, 5'd5, 0, 1'b0, edges);

    // Backpressure with a start pulse while busy
    do_dump(5'd2, 5'd4, 3, 1'b1, edges);
    chk("bp_edges", 32'(edges), 32'd15);

    // start and abort together in IDLE: nothing starts
    first_reg = 5'd9;
    last_reg  = 5'd9;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    tick();
    chk("start_abort_valid", 32'(m_valid), 32'd0);

    // Abort during SEND of the second word
    push_range(5'd10, 5'd15);
    first_reg = 5'd10;
    last_reg  = 5'd15;
    start     = 1'b1;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && q.size() == 6; i++) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 20 && m_valid !== 1'b1; i++) tick();
    chk("abort_second_valid", 32'(m_valid), 32'd1);
    base  = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr_kept", 32'(m_addr), 32'd11);
    chk("abort_data_kept", m_data, rf[11]);
    q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_no_done", 32'(done_cnt - base), 32'd0);
    do_dump(5'd7, 5'd7, 0, 1'b0, edges);

    // Reset during READ
    push_range(5'd3, 5'd6);
    first_reg = 5'd3;
    last_reg  = 5'd6;
    start     = 1'b1;
    m_ready   = 1'b0;
    tick();
    start = 1'b0;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    base    = done_cnt;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    q.delete();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_data", m_data, 32'd0);
    chk("mid_rst_addr", 32'(m_addr), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    chk("mid_rst_rf_ra", 32'(rf_ra), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_rst_no_done", 32'(done_cnt - base), 32'd0);
    chk("mid_rst_idle_valid", 32'(m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
